// File: rtl/mem_arbiter_if.sv
// Request/response bundle between NUM_PORTS memory requesters and mem_arbiter.
// Per-port fields are flattened, with port i in slice [i*W +: W].
interface mem_arbiter_if #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
);
  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        req_we;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS*DATA_W-1:0] req_bit_wr_en;
  logic [NUM_PORTS-1:0]        resp_valid;
  logic [NUM_PORTS*DATA_W-1:0] resp_rdata;
  logic [NUM_PORTS-1:0]        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_bit_wr_en,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_bit_wr_en,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Unified word-addressed memory shared by NUM_PORTS requesters through a round-robin arbiter.
// resp_valid is high in the cycle that ends at edge accept+RD_LATENCY; responses stay in accept order.
module mem_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 16384,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8);

  logic [PORT_W-1:0]    ptr_q, ptr_d;
  logic [NUM_PORTS-1:0] gnt;
  logic [PORT_W-1:0]    gnt_idx;
  logic                 gnt_any;

  // Scan from the pointer, wrapping modulo NUM_PORTS; the first valid port wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (!gnt_any && (i == (32'(ptr_q) + k) % NUM_PORTS) && bus.req_valid[i]) begin
          gnt_any = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = PORT_W'(i);
        end
      end
    end
  end

  assign bus.req_ready = gnt;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = PORT_W'((32'(gnt_idx) + 1) % NUM_PORTS);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] sel_ben;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_ben   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
        sel_ben   = bus.req_bit_wr_en[i*DATA_W +: DATA_W];
      end
    end
  end

  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  sel_idx;
  logic              in_range;

  // Byte-offset bits are dropped; any nonzero bit above the index field is out of range.
  assign word_addr = sel_addr >> OFF_W;
  assign sel_idx   = word_addr[IDX_W-1:0];
  assign in_range  = (word_addr >> IDX_W) == '0;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (gnt_any && sel_we && in_range) begin
      mem[sel_idx] <= (mem[sel_idx] & ~sel_ben) | (sel_wdata & sel_ben);
    end
  end

  logic [DATA_W-1:0] in_data;
  logic              in_err;

  assign in_data = (!sel_we && in_range) ? mem[sel_idx] : '0;
  assign in_err  = ~in_range;

  // Feed into the per-port output registers, which form the last latency stage.
  logic              fin_valid;
  logic [PORT_W-1:0] fin_port;
  logic [DATA_W-1:0] fin_data;
  logic              fin_err;

  if (RD_LATENCY > 1) begin : g_pipe
    localparam int unsigned N = RD_LATENCY - 1;

    logic [N-1:0]      v_q;
    logic [N-1:0]      err_q;
    logic [PORT_W-1:0] port_q [N];
    logic [DATA_W-1:0] data_q [N];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q    <= '0;
        err_q  <= '0;
        port_q <= '{default: '0};
        data_q <= '{default: '0};
      end else begin
        v_q[0]    <= gnt_any;
        err_q[0]  <= in_err;
        port_q[0] <= gnt_idx;
        data_q[0] <= in_data;
        for (int unsigned s = 1; s < N; s++) begin
          v_q[s]    <= v_q[s-1];
          err_q[s]  <= err_q[s-1];
          port_q[s] <= port_q[s-1];
          data_q[s] <= data_q[s-1];
        end
      end
    end

    assign fin_valid = v_q[N-1];
    assign fin_port  = port_q[N-1];
    assign fin_data  = data_q[N-1];
    assign fin_err   = err_q[N-1];
  end else begin : g_direct
    assign fin_valid = gnt_any;
    assign fin_port  = gnt_idx;
    assign fin_data  = in_data;
    assign fin_err   = in_err;
  end

  logic [NUM_PORTS-1:0] resp_valid_q;
  logic [NUM_PORTS-1:0] resp_err_q;
  logic [DATA_W-1:0]    resp_rdata_q [NUM_PORTS];

  // rdata/err of a port only move on that port's own response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      resp_rdata_q <= '{default: '0};
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        resp_valid_q[i] <= fin_valid && (32'(fin_port) == i);
        if (fin_valid && (32'(fin_port) == i)) begin
          resp_rdata_q[i] <= fin_data;
          resp_err_q[i]   <= fin_err;
        end
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rdata
    assign bus.resp_rdata[i*DATA_W +: DATA_W] = resp_rdata_q[i];
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LATENCY 1 and 3) share one stimulus stream and are
// checked against an arbiter/memory model through per-instance response scoreboards.
module tb_mem_arbiter;
  localparam int unsigned NP    = 2;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16384;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    req_valid;
  logic [NP-1:0]    req_we;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP*DW-1:0] req_ben;

  mem_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus_a ();
  mem_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus_b ();

  assign bus_a.req_valid     = req_valid;
  assign bus_a.req_we        = req_we;
  assign bus_a.req_addr      = req_addr;
  assign bus_a.req_wdata     = req_wdata;
  assign bus_a.req_bit_wr_en = req_ben;
  assign bus_b.req_valid     = req_valid;
  assign bus_b.req_we        = req_we;
  assign bus_b.req_addr      = req_addr;
  assign bus_b.req_wdata     = req_wdata;
  assign bus_b.req_bit_wr_en = req_ben;

  mem_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LATENCY(1)
  ) u_dut_lat1 (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mem_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LATENCY(3)
  ) u_dut_lat3 (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  logic [NP-1:0]    rdy   [2];
  logic [NP-1:0]    rv    [2];
  logic [NP-1:0]    rerr  [2];
  logic [NP*DW-1:0] rdata [2];

  assign rdy[0]   = bus_a.req_ready;
  assign rv[0]    = bus_a.resp_valid;
  assign rerr[0]  = bus_a.resp_err;
  assign rdata[0] = bus_a.resp_rdata;
  assign rdy[1]   = bus_b.req_ready;
  assign rv[1]    = bus_b.resp_valid;
  assign rerr[1]  = bus_b.resp_err;
  assign rdata[1] = bus_b.resp_rdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ben;
  } req_t;

  typedef struct {
    int unsigned port;
    logic [31:0] data;
    logic        err;
    int unsigned due;
  } exp_t;

  req_t        stim0[$];
  req_t        stim1[$];
  exp_t        sbq0[$];
  exp_t        sbq1[$];
  logic [31:0] mem_m [int unsigned];
  int unsigned gnt_log[$];
  int unsigned ptr_m;
  int unsigned cyc;
  int unsigned acc_cnt;
  bit [NP-1:0] acc_flag;
  bit          log_en;
  int          n_vec;
  int          n_err;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input int p, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] ben);
    req_t r;
    r.we    = we;
    r.addr  = addr;
    r.wdata = wdata;
    r.ben   = ben;
    if (p == 0) stim0.push_back(r);
    else        stim1.push_back(r);
  endtask

  task automatic check_resp(input int d);
    exp_t        e;
    bit          have;
    logic [NP-1:0]    v;
    logic [NP*DW-1:0] rd;
    logic [NP-1:0]    er;
    v    = rv[d];
    rd   = rdata[d];
    er   = rerr[d];
    have = (d == 0) ? (sbq0.size() != 0) : (sbq1.size() != 0);
    if (have) e = (d == 0) ? sbq0[0] : sbq1[0];
    if (v != '0) begin
      if (!have) begin
        check($sformatf("spurious_resp_lat%0d", 2 * d + 1), 64'(v), 64'd0);
      end else begin
        if (d == 0) void'(sbq0.pop_front());
        else        void'(sbq1.pop_front());
        check($sformatf("resp_port_lat%0d", 2 * d + 1), 64'(v), 64'(2'b01 << e.port));
        check($sformatf("resp_cycle_lat%0d", 2 * d + 1), 64'(cyc), 64'(e.due));
        check($sformatf("resp_rdata_lat%0d", 2 * d + 1), 64'(rd[e.port*32 +: 32]), 64'(e.data));
        check($sformatf("resp_err_lat%0d", 2 * d + 1), 64'(er[e.port]), 64'(e.err));
      end
    end else if (have && e.due <= cyc) begin
      if (d == 0) void'(sbq0.pop_front());
      else        void'(sbq1.pop_front());
      check($sformatf("resp_missing_lat%0d", 2 * d + 1), 64'(v), 64'(2'b01 << e.port));
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((stim0.size() + stim1.size() + sbq0.size() + sbq1.size()) != 0 || req_valid != '0) begin
      @(posedge clk);
      #2;
      n++;
      if (n > budget) begin
        check("idle_timeout", 64'(n), 64'(budget));
        stim0.delete();
        stim1.delete();
        sbq0.delete();
        sbq1.delete();
        break;
      end
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Driver: fields stay put until the model sees the request accepted.
  initial begin
    req_t r;
    bit   have;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_ben   = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (acc_flag[p] || !req_valid[p]) begin
          acc_flag[p] = 1'b0;
          have = 1'b0;
          if (p == 0 && stim0.size() > 0) begin r = stim0.pop_front(); have = 1'b1; end
          if (p == 1 && stim1.size() > 0) begin r = stim1.pop_front(); have = 1'b1; end
          req_valid[p] = have;
          if (have) begin
            req_we[p]             = r.we;
            req_addr[p*32 +: 32]  = r.addr;
            req_wdata[p*32 +: 32] = r.wdata;
            req_ben[p*32 +: 32]   = r.ben;
          end
        end
      end
    end
  end

  // Model: round-robin grant, memory, and expected responses per instance.
  initial begin
    int unsigned g;
    int unsigned pp;
    bit          found;
    logic [1:0]  exp_rdy;
    logic [31:0] a;
    logic [31:0] old;
    int unsigned idx;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < 2; k++) begin
          pp = (ptr_m + k) % 2;
          if (!found && req_valid[pp]) begin
            found = 1'b1;
            g     = pp;
          end
        end
        exp_rdy = found ? (2'b01 << g) : 2'b00;
        check("ready_lat1", 64'(rdy[0]), 64'(exp_rdy));
        check("ready_lat3", 64'(rdy[1]), 64'(exp_rdy));
        if (log_en && rdy[0] != 2'b00) gnt_log.push_back((rdy[0] == 2'b10) ? 1 : 0);

        check_resp(0);
        check_resp(1);

        if (found) begin
          a      = req_addr[g*32 +: 32];
          idx    = 32'(a[15:2]);
          e.port = g;
          e.err  = (a[31:16] != 16'h0);
          e.data = (req_we[g] || e.err) ? 32'h0 : mem_m[idx];
          if (req_we[g] && !e.err) begin
            old        = mem_m.exists(idx) ? mem_m[idx] : 32'hx;
            mem_m[idx] = (old & ~req_ben[g*32 +: 32]) | (req_wdata[g*32 +: 32] & req_ben[g*32 +: 32]);
          end
          e.due = cyc + 1;
          sbq0.push_back(e);
          e.due = cyc + 3;
          sbq1.push_back(e);
          ptr_m       = (g + 1) % 2;
          acc_flag[g] = 1'b1;
          acc_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int          n;
    int unsigned base;
    n_vec    = 0;
    n_err    = 0;
    ptr_m    = 0;
    acc_cnt  = 0;
    acc_flag = '0;
    log_en   = 1'b0;
    rst      = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_valid_%0d", d), 64'(rv[d]), 64'd0);
      check($sformatf("reset_rdata_%0d", d), 64'(rdata[d]), 64'd0);
      check($sformatf("reset_err_%0d", d), 64'(rerr[d]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Bit enables on port 0; leaves the pointer at 1.
    push(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(0, 1'b1, 32'h10, 32'h0000_0000, 32'h0000_FF00);
    push(0, 1'b0, 32'h10, 32'h0, 32'h0);
    wait_idle(50);

    // Single port write/read on port 1; pointer returns to 0.
    push(1, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    push(1, 1'b0, 32'h40, 32'h0, 32'h0);
    wait_idle(50);

    // Round-robin with both ports continuously valid.
    log_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, (i % 2 == 0) ? 32'h40 : 32'h10, 32'h0, 32'h0);
      push(1, 1'b0, (i % 2 == 0) ? 32'h10 : 32'h40, 32'h0, 32'h0);
    end
    wait_idle(60);
    log_en = 1'b0;
    check("rr_grant_count", 64'(gnt_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < gnt_log.size()) check($sformatf("rr_grant_%0d", i), 64'(gnt_log[i]), 64'(i % 2));
    end

    // Back-to-back reads on port 0 for the latency sweep.
    for (int i = 0; i < 4; i++) push(0, 1'b0, (i % 2 == 0) ? 32'h40 : 32'h10, 32'h0, 32'h0);
    wait_idle(60);

    // Out of range: aliasing onto word 0 must not happen.
    push(0, 1'b1, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);
    push(0, 1'b0, 32'h0001_0000, 32'h0, 32'h0);
    push(0, 1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(0, 1'b0, 32'h0, 32'h0, 32'h0);
    wait_idle(60);

    // Asynchronous reset with two reads in flight.
    base = acc_cnt;
    push(0, 1'b0, 32'h40, 32'h0, 32'h0);
    push(0, 1'b0, 32'h10, 32'h0, 32'h0);
    n = 0;
    while (acc_cnt < base + 2 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("rst_accepts_seen", 64'(acc_cnt - base), 64'd2);
    #3;
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_async_valid_%0d", d), 64'(rv[d]), 64'd0);
      check($sformatf("rst_async_rdata_%0d", d), 64'(rdata[d]), 64'd0);
    end
    req_valid = '0;
    acc_flag  = '0;
    stim0.delete();
    stim1.delete();
    sbq0.delete();
    sbq1.delete();
    ptr_m = 0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    push(0, 1'b0, 32'h40, 32'h0, 32'h0);
    push(1, 1'b0, 32'h10, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    check("rst_ptr_valid", 64'(req_valid), 64'(2'b11));
    check("rst_ptr_lat1", 64'(rdy[0]), 64'(2'b01));
    check("rst_ptr_lat3", 64'(rdy[1]), 64'(2'b01));
    wait_idle(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
